// File: rtl/tl_track_pkg.sv
// Shared TL-UL opcode constants, error codes and beat-count helpers for the inflight tracker.
package tl_track_pkg;

  localparam logic [2:0] A_PUT_FULL    = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] A_ARITH       = 3'd2;
  localparam logic [2:0] A_LOGICAL     = 3'd3;
  localparam logic [2:0] A_GET         = 3'd4;
  localparam logic [2:0] A_HINT        = 3'd5;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  typedef enum logic [2:0] {
    E_NONE        = 3'd0,
    E_DUP_SOURCE  = 3'd1,
    E_NO_REQ      = 3'd2,
    E_OPCODE      = 3'd3,
    E_SIZE        = 3'd4,
    E_BEAT_CHANGE = 3'd5,
    E_BAD_OPCODE  = 3'd6,
    E_TIMEOUT     = 3'd7
  } err_code_e;

  // D opcode a well-behaved slave must answer a given A opcode with.
  function automatic logic [2:0] exp_d_opcode(input logic [2:0] a_opcode);
    case (a_opcode)
      A_GET, A_ARITH, A_LOGICAL: return D_ACCESS_ACK_DATA;
      A_HINT:                    return D_HINT_ACK;
      default:                   return D_ACCESS_ACK;
    endcase
  endfunction

  function automatic logic a_has_data(input logic [2:0] a_opcode);
    return a_opcode <= A_LOGICAL;
  endfunction

  function automatic logic a_opcode_ok(input logic [2:0] a_opcode);
    return a_opcode <= A_HINT;
  endfunction

  function automatic int unsigned num_beats(input int unsigned size, input logic has_data,
                                            input int unsigned beat_lg);
    if (!has_data || size <= beat_lg) return 32'd1;
    return 32'd1 << (size - beat_lg);
  endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Tracks beat position within a TL burst; flags the first and last beat of the current transfer.
module tl_beat_counter
  import tl_track_pkg::*;
#(
  parameter int unsigned SIZE_W  = 3,
  parameter int unsigned BEAT_LG = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fire,
  input  logic [SIZE_W-1:0] size,
  input  logic              has_data,
  output logic              first,
  output logic              last
);

  localparam int unsigned MAX_LG = ((2 ** SIZE_W) - 1 > BEAT_LG) ? (2 ** SIZE_W) - 1 - BEAT_LG : 1;
  localparam int unsigned CNT_W  = MAX_LG;

  logic [CNT_W-1:0] cnt_q;
  int unsigned      beats_c;

  always_comb beats_c = num_beats(32'(size), has_data, BEAT_LG);

  assign first = (cnt_q == '0);
  assign last  = (32'(cnt_q) == beats_c - 32'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (fire) begin
      cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tl_source_inflight_tracker.sv
// Passive TL-UL scoreboard: per-source outstanding tracking with duplicate, orphan,
// mismatch, beat-change and stall detection. Drives no bus signal.
module tl_source_inflight_tracker
  import tl_track_pkg::*;
#(
  parameter int unsigned SOURCE_W = 4,
  parameter int unsigned SIZE_W   = 3,
  parameter int unsigned BEAT_LG  = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SOURCE_W-1:0]    a_source,
  input  logic [SIZE_W-1:0]      a_size,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SOURCE_W-1:0]    d_source,
  input  logic [SIZE_W-1:0]      d_size,
  output logic [2**SOURCE_W-1:0] busy,
  output logic [SOURCE_W:0]      inflight_cnt,
  output logic                   err_pulse,
  output logic                   err_sticky,
  output logic [2:0]             err_code,
  output logic [SOURCE_W-1:0]    err_source
);

  localparam int unsigned NSRC = 2 ** SOURCE_W;
  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic                a_fire, d_fire;
  logic                a_first, a_last, d_first, d_last;
  logic                unused_a_last;
  logic [2:0]          exp_op_q   [NSRC];
  logic [SIZE_W-1:0]   exp_size_q [NSRC];
  logic [2:0]          a_op_q;
  logic [SOURCE_W-1:0] a_src_q;
  logic [SIZE_W-1:0]   a_size_q;
  logic [WD_W-1:0]     wd_q, wd_next;
  logic                wd_inc, timeout_c;
  logic [NSRC-1:0]     d_clr, a_set, busy_next;
  logic [SOURCE_W:0]   cnt_next;
  logic [SOURCE_W-1:0] low_busy, a_err_src, err_src_c;
  err_code_e           d_err, a_err, err_c;

  assign a_fire        = a_valid & a_ready;
  assign d_fire        = d_valid & d_ready;
  assign unused_a_last = a_last;

  tl_beat_counter #(.SIZE_W(SIZE_W), .BEAT_LG(BEAT_LG)) u_a_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (a_fire),
    .size     (a_size),
    .has_data (a_has_data(a_opcode)),
    .first    (a_first),
    .last     (a_last)
  );

  tl_beat_counter #(.SIZE_W(SIZE_W), .BEAT_LG(BEAT_LG)) u_d_beats (
    .clock    (clock),
    .reset    (reset),
    .fire     (d_fire),
    .size     (d_size),
    .has_data (d_opcode == D_ACCESS_ACK_DATA),
    .first    (d_first),
    .last     (d_last)
  );

  // Transaction checks against pre-cycle state; a D clear frees its source for a same-cycle A.
  always_comb begin
    d_clr     = '0;
    a_set     = '0;
    d_err     = E_NONE;
    a_err     = E_NONE;
    a_err_src = a_source;
    if (d_fire && d_first) begin
      if (!busy[d_source])                         d_err = E_NO_REQ;
      else if (exp_op_q[d_source] != d_opcode)     d_err = E_OPCODE;
      else if (exp_size_q[d_source] != d_size)     d_err = E_SIZE;
    end
    if (d_fire && d_last && busy[d_source]) d_clr[d_source] = 1'b1;
    if (a_fire && a_first) begin
      if (!a_opcode_ok(a_opcode))                  a_err = E_BAD_OPCODE;
      else if (busy[a_source] && !d_clr[a_source]) a_err = E_DUP_SOURCE;
      else                                         a_set[a_source] = 1'b1;
    end else if (a_fire && (a_opcode != a_op_q || a_source != a_src_q || a_size != a_size_q)) begin
      a_err     = E_BEAT_CHANGE;
      a_err_src = a_src_q;
    end
    busy_next = (busy & ~d_clr) | a_set;
  end

  // Watchdog, population count and error arbitration (D over A over timeout).
  always_comb begin
    wd_inc    = (inflight_cnt != '0) && !d_fire;
    timeout_c = (TIMEOUT != 0) && wd_inc && (32'(wd_q) == TIMEOUT - 32'd1);
    wd_next   = '0;
    if (TIMEOUT != 0 && wd_inc) wd_next = (32'(wd_q) == TIMEOUT) ? wd_q : wd_q + WD_W'(1);

    low_busy = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (busy[i]) low_busy = SOURCE_W'(i);
    end

    cnt_next = '0;
    for (int i = 0; i < int'(NSRC); i++) cnt_next = cnt_next + (SOURCE_W + 1)'(busy_next[i]);

    err_c     = E_NONE;
    err_src_c = '0;
    if (d_err != E_NONE) begin
      err_c     = d_err;
      err_src_c = d_source;
    end else if (a_err != E_NONE) begin
      err_c     = a_err;
      err_src_c = a_err_src;
    end else if (timeout_c) begin
      err_c     = E_TIMEOUT;
      err_src_c = low_busy;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy         <= '0;
      inflight_cnt <= '0;
      err_pulse    <= 1'b0;
      err_sticky   <= 1'b0;
      err_code     <= '0;
      err_source   <= '0;
      wd_q         <= '0;
      a_op_q       <= '0;
      a_src_q      <= '0;
      a_size_q     <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        exp_op_q[i]   <= '0;
        exp_size_q[i] <= '0;
      end
    end else begin
      busy         <= busy_next;
      inflight_cnt <= cnt_next;
      wd_q         <= wd_next;
      err_pulse    <= (err_c != E_NONE);
      if (err_c != E_NONE && !err_sticky) begin
        err_sticky <= 1'b1;
        err_code   <= err_c;
        err_source <= err_src_c;
      end
      if (a_fire && a_first) begin
        a_op_q   <= a_opcode;
        a_src_q  <= a_source;
        a_size_q <= a_size;
      end
      for (int i = 0; i < int'(NSRC); i++) begin
        if (a_set[i]) begin
          exp_op_q[i]   <= exp_d_opcode(a_opcode);
          exp_size_q[i] <= a_size;
        end
      end
    end
  end

endmodule
